// File: rtl/ept_uc_pkg.sv
// Shared widths and FSM state encoding for the uc_out arbiter.
package ept_uc_pkg;
  localparam int UC_OUT_W = 30;
  localparam int UC_IN_W  = 22;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } uc_state_e;
endpackage

// File: rtl/ept_uc_out_arbiter_if.sv
// Request/grant bundle between the user modules and the uc_out arbiter.
interface ept_uc_out_arbiter_if #(
  parameter int N   = 2,
  parameter int IDW = 4
) ();
  logic [N-1:0]                     req;
  logic [N*ept_uc_pkg::UC_OUT_W-1:0] uc_out_m;
  logic [N-1:0]                     gnt;
  logic [IDW-1:0]                   gnt_id;
  logic [ept_uc_pkg::UC_OUT_W-1:0]   uc_out;
  logic                             busy;
  logic [N-1:0]                     preempt;

  // Arbiter side
  modport slave (
    input  req, uc_out_m,
    output gnt, gnt_id, uc_out, busy, preempt
  );

  // User-module side
  modport master (
    output req, uc_out_m,
    input  gnt, gnt_id, uc_out, busy, preempt
  );
endinterface

// File: rtl/ept_rr_pick.sv
// Combinational round-robin pick: first requester at index >= ptr, wrapping.
module ept_rr_pick #(
  parameter int N   = 2,
  parameter int IDW = 4
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] sel,
  output logic           any
);
  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;

  // Lower copy masked below ptr, upper copy left whole so the search wraps.
  always_comb begin
    dbl    = {req, req};
    masked = '0;
    for (int i = 0; i < 2*N; i++)
      masked[i] = dbl[i] & ((i >= N) || (i >= int'(ptr)));
    sel = '0;
    for (int i = 2*N-1; i >= 0; i--)
      if (masked[i]) sel = (i >= N) ? IDW'(i - N) : IDW'(i);
  end

  assign any = |req;
endmodule

// File: rtl/ept_uc_out_arbiter.sv
// Round-robin, grant-gated, registered mux of N module words onto uc_out,
// with a hold limit that hands the bus over when others are waiting.
module ept_uc_out_arbiter
  import ept_uc_pkg::*;
#(
  parameter int N        = 2,
  parameter int MAX_HOLD = 256,
  parameter int IDW      = 4
) (
  input logic                  uc_clk,
  input logic                  uc_reset,
  ept_uc_out_arbiter_if.slave  bus
);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  uc_state_e             state_q;
  logic [N-1:0]          gnt_q;
  logic [N-1:0]          preempt_q;
  logic [IDW-1:0]        gnt_id_q;
  logic [IDW-1:0]        rr_ptr_q;
  logic [UC_OUT_W-1:0]   uc_out_q;
  logic                  busy_q;
  logic [HW-1:0]         hold_q;

  logic [IDW-1:0]        sel;
  logic                  any;
  logic [N-1:0]          sel_oh;
  logic [UC_OUT_W-1:0]   word;
  logic                  release_c;
  logic                  limit_c;

  ept_rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req (bus.req),
    .ptr (rr_ptr_q),
    .sel (sel),
    .any (any)
  );

  always_comb begin
    word      = '0;
    sel_oh    = '0;
    release_c = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (gnt_id_q == IDW'(i)) begin
        word      = bus.uc_out_m[i*UC_OUT_W +: UC_OUT_W];
        release_c = ~bus.req[i];
      end
      if (sel == IDW'(i)) sel_oh[i] = 1'b1;
    end
    limit_c = (MAX_HOLD != 0) && (hold_q == HOLD_LAST) && ((bus.req & ~gnt_q) != '0);
  end

  always_ff @(posedge uc_clk or posedge uc_reset) begin
    if (uc_reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      uc_out_q  <= '0;
      busy_q    <= 1'b0;
      preempt_q <= '0;
      rr_ptr_q  <= '0;
      hold_q    <= '0;
    end else begin
      preempt_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (any) begin
            state_q  <= ST_GRANT;
            gnt_q    <= sel_oh;
            gnt_id_q <= sel;
            busy_q   <= 1'b1;
            hold_q   <= '0;
          end
        end
        ST_GRANT: begin
          if (release_c || limit_c) begin
            // A voluntary release wins over a coincident hold-limit hit.
            state_q  <= ST_GAP;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            uc_out_q <= '0;
            if (!release_c) preempt_q <= gnt_q;
          end else begin
            uc_out_q <= word;
            if (hold_q != HOLD_MAX) hold_q <= hold_q + 1'b1;
          end
        end
        ST_GAP: begin
          uc_out_q <= '0;
          rr_ptr_q <= (gnt_id_q == IDW'(N-1)) ? '0 : gnt_id_q + 1'b1;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.uc_out  = uc_out_q;
  assign bus.busy    = busy_q;
  assign bus.preempt = preempt_q;
endmodule
